// File: rtl/clk_div_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_monitor_if
//  Purpose  : Bundles the monitored slow clock, the clear control and every
//             measurement output of clk_div_monitor into one interface.
//  Ports    : slow_i    - asynchronous slow square wave being monitored
//             clear_i   - synchronous request to drop lock and re-measure
//             rise_o    - one-cycle strobe per synchronised rising edge
//             fall_o    - one-cycle strobe per synchronised falling edge
//             period_o  - last completed rise-to-rise period (clk_i cycles)
//             high_o    - last completed rise-to-fall high time
//             locked_o  - period has been stable long enough
//             timeout_o - sticky, no rising edge before the counter saturated
//  Modports : master - the side that drives slow_i/clear_i and reads results
//             slave  - the monitor itself
//  Revision : 1.0 - initial release
// ============================================================================
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             slow_i;
    logic             clear_i;
    logic             rise_o;
    logic             fall_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             locked_o;
    logic             timeout_o;

    modport master (
        output slow_i,
        output clear_i,
        input  rise_o,
        input  fall_o,
        input  period_o,
        input  high_o,
        input  locked_o,
        input  timeout_o
    );

    modport slave (
        input  slow_i,
        input  clear_i,
        output rise_o,
        output fall_o,
        output period_o,
        output high_o,
        output locked_o,
        output timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_monitor
//  Purpose  : Brings a slow divided clock (or any slow square wave) into the
//             fast clk_i domain. Produces single-cycle rise/fall strobes for
//             use as clock enables, measures period and high time in clk_i
//             cycles and declares lock once successive periods agree.
//  Ports    : clk_i  - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             mon    - clk_div_monitor_if.slave (slow_i, clear_i in;
//                      rise_o, fall_o, period_o, high_o, locked_o,
//                      timeout_o out)
//  Params   : CNT_W      - width of the period/high counters and outputs
//             LOCK_COUNT - consecutive agreeing periods needed for lock
//                          (2..15)
//             TOL        - largest period difference still called a match
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  wire              clk_i,
    input  wire              rst_n,
    clk_div_monitor_if.slave mon
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   c_TOL       = TOL[CNT_W:0];
    // match_cnt value that, with one more agreeing period, completes lock
    localparam logic [3:0]       c_LOCK_LAST = 4'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,   // no reference rise yet, period unknown
        ST_MEASURE = 2'd1,   // measuring, not yet stable
        ST_LOCKED  = 2'd2    // LOCK_COUNT agreeing periods seen
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_rise;
    logic             w_fall;
    logic             r_rise;
    logic             r_fall;

    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_per_sat;

    logic [CNT_W:0]   w_per_ext;
    logic [CNT_W:0]   w_prd_ext;
    logic [CNT_W:0]   w_diff;
    logic             w_match;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_match_cnt;
    logic [3:0]       w_match_nxt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_period_load;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser plus edge register. Edges are detected between
    // the second sync stage and its delayed copy, so both flops have fully
    // settled before anything downstream depends on them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= mon.slow_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;

    // ------------------------------------------------------------------------
    // Period and high-time counters. Both reload to 1 on the rising edge so
    // that the value present at the next edge is the length in cycles.
    // ------------------------------------------------------------------------
    assign w_per_sat = (r_per_cnt == c_CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            if (w_rise) begin
                r_per_cnt <= c_CNT_ONE;
            end else if (!w_per_sat) begin
                r_per_cnt <= r_per_cnt + c_CNT_ONE;
            end

            if (w_rise) begin
                r_hi_cnt <= c_CNT_ONE;
            end else if (r_sync2 && (r_hi_cnt != c_CNT_MAX)) begin
                r_hi_cnt <= r_hi_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Period comparison, done one bit wider so the subtraction cannot wrap.
    // Compared against the previously published period.
    // ------------------------------------------------------------------------
    assign w_per_ext = {1'b0, r_per_cnt};
    assign w_prd_ext = {1'b0, r_period};
    assign w_diff    = (w_per_ext >= w_prd_ext) ? (w_per_ext - w_prd_ext)
                                                : (w_prd_ext - w_per_ext);
    assign w_match   = (w_diff <= c_TOL);

    // ------------------------------------------------------------------------
    // Lock state machine: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_match_cnt <= 4'd0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_locked    <= w_locked_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Lock state machine: next state and registered-output updates.
    // Priority: clear, then a rising edge, then counter saturation. A rise
    // arriving together with saturation is a valid full-scale period.
    // match_cnt == 0 marks "no previous period to compare against", which is
    // the case for the first measurement after SEARCH.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_match_nxt   = r_match_cnt;
        w_locked_nxt  = r_locked;
        w_timeout_nxt = r_timeout;
        w_period_load = 1'b0;

        if (mon.clear_i) begin
            w_locked_nxt  = 1'b0;
            w_timeout_nxt = 1'b0;
            w_match_nxt   = 4'd0;
            // A coincident rise acts as the first rise of SEARCH.
            w_state_nxt   = w_rise ? ST_MEASURE : ST_SEARCH;
        end else if (w_rise) begin
            w_timeout_nxt = 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    // Reference edge only; no complete period exists yet.
                    w_state_nxt = ST_MEASURE;
                    w_match_nxt = 4'd0;
                end
                ST_MEASURE: begin
                    w_period_load = 1'b1;
                    if (r_match_cnt == 4'd0) begin
                        w_match_nxt = 4'd1;
                    end else if (w_match) begin
                        w_match_nxt = r_match_cnt + 4'd1;
                        if (r_match_cnt == c_LOCK_LAST) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_match_nxt = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    w_period_load = 1'b1;
                    if (!w_match) begin
                        // The disagreeing period starts a new run.
                        w_state_nxt  = ST_MEASURE;
                        w_locked_nxt = 1'b0;
                        w_match_nxt  = 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_match_nxt = 4'd0;
                end
            endcase
        end else if (w_per_sat) begin
            w_state_nxt   = ST_SEARCH;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_match_nxt   = 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Published measurements. These hold across clear and timeout so the
    // last known values stay visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_high   <= '0;
        end else begin
            if (w_period_load) begin
                r_period <= r_per_cnt;
            end
            if (w_fall) begin
                r_high <= r_hi_cnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mon.rise_o    = r_rise;
    assign mon.fall_o    = r_fall;
    assign mon.period_o  = r_period;
    assign mon.high_o    = r_high;
    assign mon.locked_o  = r_locked;
    assign mon.timeout_o = r_timeout;

endmodule
`default_nettype wire
